// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word at a time over req/ready and
// computes the next PC. Optional ALIGN_CHECK_EN adds a misalign output and a HALT state.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  input  logic              stall,
  input  logic              PCSrc,
  input  logic [1:0]        Jump,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
`ifdef ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

`ifdef ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2} state_e;
`else
  typedef enum logic [0:0] {S_FETCH = 1'b0, S_EXEC = 1'b1} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              req_en_q;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jmp_target;

  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign br_off     = {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jmp_target = {pc_plus4[ADDR_W-1:28], instr_q[25:0], 2'b00};

  // Jump selects dominate PCSrc; the reserved encoding falls through to pc+4.
  always_comb begin
    next_pc = pc_plus4;
    case (Jump)
      2'b01:   next_pc = jmp_target;
      2'b10:   next_pc = jr_target;
      2'b00:   next_pc = PCSrc ? (pc_plus4 + br_off) : pc_plus4;
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_FETCH: begin
        // req_en_q keeps the request low during the first cycle out of reset.
        imem_req = req_en_q;
        if (req_en_q && imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
`ifdef ALIGN_CHECK_EN
          pc_d    = next_pc;
          state_d = (next_pc[1:0] != 2'b00) ? S_HALT : S_FETCH;
`else
          pc_d    = next_pc & ~ADDR_W'(3);
          state_d = S_FETCH;
`endif
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_en_q <= 1'b1;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
`ifdef ALIGN_CHECK_EN
  assign misalign  = (state_q == S_HALT);
`endif

endmodule
